pmod_button_reader: RTL and testbench

- Input-side counterpart to the PMOD LED drivers: samples eight active-low button/switch lines on one PMOD port.
- Per line: synchronises, debounces and turns changes into press/release events.
- Events are queued in a small FIFO with a valid/ready handshake for downstream logic (LED patterns, soft CPU).
- Also exposes the debounced level of every line.

---
 rtl/pmod_button_reader.sv | 163 ++++++++++++++++
 tb/tb_pmod_button_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pmod_button_reader.sv
// Eight-line PMOD button reader: synchronise, debounce and queue press/release events.
// Optional long-press events are enabled by defining PMOD_BTN_LONGPRESS_EN.
module pmod_button_reader #(
    parameter int TICK_DIV       = 48000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int LONG_TICKS     = 1000
) (
    input  logic       CLK_48,
    input  logic       RST_N,
    input  logic [7:0] pmod_in,
    output logic [7:0] btn_state,
    output logic       evt_valid,
    output logic [4:0] evt_data,
    input  logic       evt_ready,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    sync1, sync2, pressed_sync;
    logic [PW-1:0] presc;
    logic          tick;
    logic [CW-1:0] db_cnt [8];
    logic [7:0]    flip;
    logic [7:0]    pend, pend_dir;
    logic [7:0]    grant_pr;
    logic          push_req, push, pop, drop, full, empty;
    logic [4:0]    push_data;
    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, rd_nxt, count;

    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
        end else begin
            sync1 <= pmod_in;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = ~sync2;
    assign tick         = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) presc <= '0;
        else        presc <= tick ? '0 : presc + 1'b1;
    end

    always_comb begin
        flip = '0;
        for (int i = 0; i < 8; i++)
            flip[i] = (pressed_sync[i] != btn_state[i]) && tick &&
                      (db_cnt[i] == CW'(DEBOUNCE_TICKS - 1));
    end

    // Any cycle where the synced level matches the accepted one restarts the count.
    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            btn_state <= '0;
            pend      <= '0;
            pend_dir  <= '0;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            btn_state <= btn_state ^ flip;
            for (int i = 0; i < 8; i++) begin
                if (pressed_sync[i] == btn_state[i] || flip[i]) db_cnt[i] <= '0;
                else if (tick)                                  db_cnt[i] <= db_cnt[i] + 1'b1;
                if (grant_pr[i]) pend[i] <= 1'b0;
                if (flip[i]) begin
                    pend[i]     <= 1'b1;
                    pend_dir[i] <= ~btn_state[i];
                end
            end
        end
    end

`ifdef PMOD_BTN_LONGPRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);

    logic [HW-1:0] hold_cnt [8];
    logic [7:0]    long_pend, grant_lg;

    // Hold counter saturates at LONG_TICKS so each press yields one long event.
    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            long_pend <= '0;
            for (int i = 0; i < 8; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!btn_state[i])                                hold_cnt[i] <= '0;
                else if (tick && hold_cnt[i] != HW'(LONG_TICKS)) hold_cnt[i] <= hold_cnt[i] + 1'b1;
                if (grant_lg[i]) long_pend[i] <= 1'b0;
                if (btn_state[i] && tick && hold_cnt[i] == HW'(LONG_TICKS - 1))
                    long_pend[i] <= 1'b1;
            end
        end
    end
`endif

    // Lowest channel wins; press/release is served before long at the same index.
    always_comb begin
        push_req  = 1'b0;
        push_data = '0;
        grant_pr  = '0;
`ifdef PMOD_BTN_LONGPRESS_EN
        grant_lg  = '0;
`endif
        for (int i = 0; i < 8; i++) begin
            if (!push_req && pend[i]) begin
                push_req    = 1'b1;
                push_data   = {1'b0, pend_dir[i], 3'(i)};
                grant_pr[i] = 1'b1;
            end
`ifdef PMOD_BTN_LONGPRESS_EN
            else if (!push_req && long_pend[i]) begin
                push_req    = 1'b1;
                push_data   = {2'b10, 3'(i)};
                grant_lg[i] = 1'b1;
            end
`endif
        end
    end

    assign count     = wr_ptr - rd_ptr;
    assign rd_nxt    = rd_ptr + 1'b1;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            evt_data <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_nxt;
            // evt_data mirrors the entry that will be at the head next cycle.
            if (pop && count > (AW+1)'(1))
                evt_data <= mem[rd_nxt[AW-1:0]];
            else if (push && (empty || (pop && count == (AW+1)'(1))))
                evt_data <= push_data;
            else if (pop)
                evt_data <= '0;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pmod_button_reader.sv
// Bench for pmod_button_reader: table of pin patterns plus hand-written corner sequences.
module tb_pmod_button_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pmod_in;
    logic [7:0] btn_state;
    logic       evt_valid;
    logic [4:0] evt_data;
    logic       evt_ready;
    logic       overflow;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [4:0] exp_q[$];
    int         pop_log[$];

    typedef struct {
        logic [7:0] pins;
        logic [7:0] exp_state;
    } vec_t;

    vec_t vecs[7];

    pmod_button_reader #(
        .TICK_DIV(16), .DEBOUNCE_TICKS(3), .FIFO_DEPTH(4), .LONG_TICKS(8)
    ) dut (
        .CLK_48(clk), .RST_N(rst_n), .pmod_in(pmod_in), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted event is compared against the expected queue.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%b expected=none", evt_data);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    errors++;
                    $display("FAIL event_data got=%b expected=%b", evt_data, e);
                end
            end
            pop_log.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        step(20);
    endtask

    task automatic expect_changes(input logic [7:0] old_p, input logic [7:0] new_p);
        for (int ch = 0; ch < 8; ch++)
            if (old_p[ch] != new_p[ch]) exp_q.push_back({1'b0, new_p[ch], 3'(ch)});
    endtask

    initial begin
        logic [7:0] prev;
        logic [4:0] head;
        int         nchg;
        logic       saw_valid;

        vecs[0] = '{8'hFB, 8'h04};
        vecs[1] = '{8'hFF, 8'h00};
        vecs[2] = '{8'hDD, 8'h22};
        vecs[3] = '{8'hFF, 8'h00};
        vecs[4] = '{8'hFA, 8'h05};
        vecs[5] = '{8'hAF, 8'h50};
        vecs[6] = '{8'hFF, 8'h00};

        rst_n = 1'b0; pmod_in = 8'hFF; evt_ready = 1'b1; ovf_clr = 1'b0;
        step(5);
        chk("reset_btn_state", btn_state, 8'h00);
        chk("reset_evt_valid", evt_valid, 1'b0);
        chk("reset_evt_data", evt_data, 5'd0);
        chk("reset_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (evt_valid) saw_valid = 1'b1;
        end
        step(1);
        chk("idle_no_event", saw_valid, 1'b0);

        // Table of pin patterns; events modelled from the change in pressed mask.
        prev = 8'h00;
        for (int v = 0; v < 7; v++) begin
            pop_log.delete();
            pmod_in = vecs[v].pins;
            expect_changes(prev, ~vecs[v].pins);
            nchg = exp_q.size();
            wait_drain($sformatf("vec%0d", v), 200);
            chk($sformatf("vec%0d_btn_state", v), btn_state, vecs[v].exp_state);
            chk($sformatf("vec%0d_event_count", v), pop_log.size(), nchg);
            for (int k = 1; k < pop_log.size(); k++)
                chk($sformatf("vec%0d_consecutive", v), pop_log[k] - pop_log[k-1], 1);
            prev = ~vecs[v].pins;
        end

        // Bounce on channel 0: 20-cycle pulses never survive 3 ticks.
        for (int i = 0; i < 10; i++) begin
            pmod_in[0] = ~pmod_in[0];
            step(20);
        end
        pmod_in = 8'hFF;
        step(100);
        chk("bounce_btn_state0", btn_state[0], 1'b0);
        chk("bounce_no_event", exp_q.size(), 0);

        // Stalled consumer: five presses, fifth is dropped.
        evt_ready = 1'b0;
        pmod_in = 8'h26;
        exp_q.push_back(5'b01_000);
        exp_q.push_back(5'b01_011);
        exp_q.push_back(5'b01_100);
        exp_q.push_back(5'b01_110);
        step(70);
        chk("ovf_btn_state", btn_state, 8'hD9);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_valid", evt_valid, 1'b1);
        head = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_head_stable", evt_data, head);
        end
        step(1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        evt_ready = 1'b1;
        wait_drain("ovf", 50);
        chk("ovf_empty_after_drain", evt_valid, 1'b0);
        pmod_in = 8'hFF;
        expect_changes(8'hD9, 8'h00);
        wait_drain("ovf_release", 200);
        chk("ovf_release_state", btn_state, 8'h00);

        // Reset mid-operation discards queued and pending events.
        evt_ready = 1'b0;
        pmod_in = 8'hFB;
        step(70);
        chk("mid_valid_before_reset", evt_valid, 1'b1);
        pmod_in = 8'hFF;
        rst_n = 1'b0;
        step(2);
        chk("mid_reset_valid", evt_valid, 1'b0);
        chk("mid_reset_state", btn_state, 8'h00);
        chk("mid_reset_data", evt_data, 5'd0);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        step(100);
        chk("mid_reset_quiet", evt_valid, 1'b0);

`ifdef PMOD_BTN_LONGPRESS_EN
        pmod_in = 8'h7F;
        exp_q.push_back(5'b01_111);
        exp_q.push_back(5'b10_111);
        step(20 * 16);
        chk("long_queue_empty", exp_q.size(), 0);
        pmod_in = 8'hFF;
        exp_q.push_back(5'b00_111);
        wait_drain("long_release", 200);
        chk("long_release_state", btn_state, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
